rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Writeback arbiter and write-port driver for the 32×32 register file. It merges two writeback sources into the register file's single synchronous write port: the single-cycle ALU path, which can never stall, and the long-latency load path, which uses a valid/ready handshake into a small queue. It keeps a pending-load scoreboard for hazard detection, and raises a stall request when queued loads are starved. It sits between the execute/memory stages and the register file write inputs.

## Interface
- DEPTH, 4, load-queue entries; power of 2, ≥2
- STARVE_MAX, 3, consecutive cycles a non-empty queue may go without draining before STALL_REQ asserts; ≥1
- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  reset, synchronous, active-low
- ALU_valid  in  1  ALU writeback request this cycle; no backpressure
- ALU_wa  in  5  ALU destination register
- ALU_wd  in  32  ALU write data
- LD_valid  in  1  load writeback offered
- LD_ready  out  1  queue can accept; handshake when LD_valid && LD_ready
- LD_wa  in  5  load destination register
- LD_wd  in  32  load data
- SB_set  in  1  load issued; mark SB_rd pending
- SB_rd  in  5  destination of issued load
- RF_en  out  1  register-file write enable (registered)
- RF_wa  out  5  register-file write address (registered)
- RF_wd  out  32  register-file write data (registered)
- PEND  out  32  pending-load bitmap; bit 0 always 0
- STALL_REQ  out  1  request upstream to withhold ALU_valid next cycle
- Q_count  out  $clog2(DEPTH)+1  queue occupancy

## Operation
- Each cycle, one source is selected and its write is registered onto RF_en/RF_wa/RF_wd.
  - ALU_valid=1: the ALU write is selected. The queue head does not pop.
  - ALU_valid=0 and queue non-empty: the queue head pops and is selected.
  - Otherwise: RF_en=0 next cycle. RF_wa and RF_wd hold their previous values.
- Register 0 writes: RF_en is registered as 0. A queue entry with wa=0 still pops.
- Queue: FIFO with DEPTH entries and wrapping read/write pointers.
  - LD_ready = RST_N && (Q_count != DEPTH).
  - Full is judged at the start of the cycle. There is no push into a full queue, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave Q_count unchanged.
- Scoreboard:
  - SB_set with SB_rd≠0 sets PEND[SB_rd].
  - Popping an entry with wa=w clears PEND[w].
  - When a set and a clear hit the same bit in the same cycle, set wins.
  - SB_rd=0 is ignored.
- Starvation: the counter increments each cycle in which the queue is non-empty and ALU_valid=1.
  - It resets to 0 on any pop or when the queue is empty.
  - STALL_REQ is registered: it is 1 when the counter ≥ STARVE_MAX, and 0 otherwise.
  - While STALL_REQ=1, upstream guarantees ALU_valid=0 on the following cycle. If ALU_valid=1 arrives anyway, it is still honoured; ALU priority is never violated.
- Upstream guarantees no ALU write targets a register with PEND set (no WAW hazard). The block does not check this.

## Timing
- Reset (RST_N=0 at an edge) produces:
  - RF_en=0, RF_wa=0, RF_wd=0.
  - PEND=0, STALL_REQ=0, Q_count=0, starvation counter=0, pointers=0.
  - LD_ready=0 combinationally while RST_N=0.
  - Handshakes and SB_set during reset are ignored.
  - Reset mid-operation discards all queued entries.
- ALU latency: ALU_valid in cycle N gives RF_en=1 during N+1. The register-file write then commits at the end of N+1.
- Load latency, minimum 2 cycles:
  - Handshake in cycle N writes the entry at the end of N.
  - The entry can pop in N+1 and appears on RF_en during N+2.
  - There is no bypass around the queue.
  - The PEND clear is visible in N+2, together with RF_en.
- PEND set is visible the cycle after SB_set.
- Q_count updates at the edge following a push or pop.
- Back-to-back: with ALU_valid=0 continuously, one load writes per cycle, so throughput is 1 per cycle.

## Test plan
- Reset then idle: RST_N low 2 cycles, then high.
  - Required: all outputs 0 and LD_ready=0 during reset.
  - Required: LD_ready=1 and Q_count=0 after reset.
- ALU path: ALU_valid=1, ALU_wa=5, ALU_wd=0xDEADBEEF in cycle N.
  - Required: RF_en=1, RF_wa=5, RF_wd=0xDEADBEEF in N+1; RF_en=0 in N+2.
  - Required: the same stimulus with ALU_wa=0 gives RF_en=0.
- Load path and scoreboard: SB_set with rd=7, then a load handshake (wa=7, wd=0x12345678) in cycle N with ALU idle.
  - Required: PEND[7]=1 after the set.
  - Required: RF_en/wa/wd = 1/7/0x12345678 in N+2, with PEND[7]=0 in N+2.
- Full queue: ALU_valid=1 continuously and DEPTH+1 loads offered.
  - Required: exactly 4 accepted, then LD_ready=0 and Q_count=4.
  - Required: drops ALU_valid → 4 writes in FIFO order on 4 consecutive cycles, with LD_ready=1 after the first pop.
- Starvation: 1 load queued, ALU_valid=1 for 5 cycles.
  - Required: STALL_REQ=1 after 3 starved cycles.
  - Required: when ALU_valid drops, the load pops, the counter clears, and STALL_REQ=0 on the next cycle.
- Set/clear collision: pop of an entry with wa=9 in the same cycle as SB_set rd=9.
  - Required: PEND[9]=1 afterward.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges ALU and queued load writebacks onto one RF write port with a pending-load scoreboard
module rf_wb_arbiter #(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     ALU_valid,
   input  logic [4:0]               ALU_wa,
   input  logic [31:0]              ALU_wd,
   input  logic                     LD_valid,
   output logic                     LD_ready,
   input  logic [4:0]               LD_wa,
   input  logic [31:0]              LD_wd,
   input  logic                     SB_set,
   input  logic [4:0]               SB_rd,
   output logic                     RF_en,
   output logic [4:0]               RF_wa,
   output logic [31:0]              RF_wd,
   output logic [31:0]              PEND,
   output logic                     STALL_REQ,
   output logic [$clog2(DEPTH):0]   Q_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);
   logic [4:0]    r_mem_wa [DEPTH];
   logic [31:0]   r_mem_wd [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [SW-1:0] r_starve;
   logic          w_full, w_empty, w_push, w_pop;
   logic [4:0]    w_head_wa;
   logic [31:0]   w_head_wd, w_clr, w_set;
   logic [SW-1:0] w_starve_nx;
   always_comb begin
      w_full      = Q_count == CW'(DEPTH);
      w_empty     = Q_count == '0;
      LD_ready    = RST_N && !w_full;
      w_push      = LD_valid && LD_ready;
      w_pop       = !ALU_valid && !w_empty;
      w_head_wa   = r_mem_wa[r_rp];
      w_head_wd   = r_mem_wd[r_rp];
      w_clr       = w_pop ? 32'(1) << w_head_wa : '0;
      w_set       = (SB_set && |SB_rd) ? 32'(1) << SB_rd : '0;
      // a non-empty queue that does not pop is necessarily being starved by the ALU
      w_starve_nx = (w_pop || w_empty) ? '0 :
                    (r_starve == SW'(STARVE_MAX)) ? r_starve : r_starve + 1'b1;
   end
   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_mem_wa[r_wp] <= LD_wa;
         r_mem_wd[r_wp] <= LD_wd;
      end
   end
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         RF_en     <= 1'b0;
         RF_wa     <= '0;
         RF_wd     <= '0;
         PEND      <= '0;
         STALL_REQ <= 1'b0;
         Q_count   <= '0;
         r_starve  <= '0;
         r_wp      <= '0;
         r_rp      <= '0;
      end else begin
         RF_en <= ALU_valid ? |ALU_wa : (w_pop && |w_head_wa);
         if (ALU_valid || w_pop) begin
            RF_wa <= ALU_valid ? ALU_wa : w_head_wa;
            RF_wd <= ALU_valid ? ALU_wd : w_head_wd;
         end
         PEND      <= ((PEND & ~w_clr) | w_set) & ~32'd1;
         STALL_REQ <= w_starve_nx >= SW'(STARVE_MAX);
         r_starve  <= w_starve_nx;
         Q_count   <= Q_count + CW'(w_push) - CW'(w_pop);
         r_wp      <= r_wp + AW'(w_push);
         r_rp      <= r_rp + AW'(w_pop);
      end
   end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
   logic        CLK = 1'b0, RST_N = 1'b0;
   logic        ALU_valid = 1'b0, LD_valid = 1'b0, SB_set = 1'b0;
   logic [4:0]  ALU_wa = '0, LD_wa = '0, SB_rd = '0;
   logic [31:0] ALU_wd = '0, LD_wd = '0;
   logic        LD_ready, RF_en, STALL_REQ;
   logic [4:0]  RF_wa;
   logic [31:0] RF_wd, PEND;
   logic [2:0]  Q_count;
   int          tests = 0, fails = 0;
   rf_wb_arbiter #(.DEPTH(4), .STARVE_MAX(3)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .ALU_valid(ALU_valid), .ALU_wa(ALU_wa), .ALU_wd(ALU_wd),
      .LD_valid(LD_valid), .LD_ready(LD_ready), .LD_wa(LD_wa), .LD_wd(LD_wd),
      .SB_set(SB_set), .SB_rd(SB_rd),
      .RF_en(RF_en), .RF_wa(RF_wa), .RF_wd(RF_wd),
      .PEND(PEND), .STALL_REQ(STALL_REQ), .Q_count(Q_count)
   );
   always #5 CLK = ~CLK;
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask
   task automatic test_reset();
      LD_valid = 1'b1; LD_wa = 5'd3; SB_set = 1'b1; SB_rd = 5'd4;
      #1;
      tests++; if (LD_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %0b exp 0", LD_ready); end
      cyc(); cyc();
      tests++; if ({RF_en, RF_wa, RF_wd} !== 38'd0) begin fails++; $display("FAIL rst_rf got %0b/%0d/%h exp 0/0/0", RF_en, RF_wa, RF_wd); end
      tests++; if (PEND !== 32'd0 || STALL_REQ !== 1'b0 || Q_count !== 3'd0) begin fails++; $display("FAIL rst_state got pend=%h stall=%0b q=%0d exp 0/0/0", PEND, STALL_REQ, Q_count); end
      tests++; if (LD_ready !== 1'b0) begin fails++; $display("FAIL rst_ready2 got %0b exp 0", LD_ready); end
      RST_N = 1'b1; LD_valid = 1'b0; SB_set = 1'b0;
      #1;
      tests++; if (LD_ready !== 1'b1 || Q_count !== 3'd0) begin fails++; $display("FAIL post_rst got ready=%0b q=%0d exp 1/0", LD_ready, Q_count); end
   endtask
   task automatic test_alu();
      ALU_valid = 1'b1; ALU_wa = 5'd5; ALU_wd = 32'hDEADBEEF;
      cyc();
      ALU_valid = 1'b0;
      tests++; if ({RF_en, RF_wa, RF_wd} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin fails++; $display("FAIL alu_write got %0b/%0d/%h exp 1/5/deadbeef", RF_en, RF_wa, RF_wd); end
      cyc();
      tests++; if (RF_en !== 1'b0 || RF_wa !== 5'd5) begin fails++; $display("FAIL alu_idle got en=%0b wa=%0d exp 0/5", RF_en, RF_wa); end
      ALU_valid = 1'b1; ALU_wa = 5'd0;
      cyc();
      ALU_valid = 1'b0;
      tests++; if (RF_en !== 1'b0) begin fails++; $display("FAIL alu_r0 got %0b exp 0", RF_en); end
   endtask
   task automatic test_load();
      SB_set = 1'b1; SB_rd = 5'd7;
      cyc();
      SB_set = 1'b0;
      tests++; if (PEND !== 32'h80) begin fails++; $display("FAIL pend_set got %h exp 00000080", PEND); end
      LD_valid = 1'b1; LD_wa = 5'd7; LD_wd = 32'h12345678;
      cyc();
      LD_valid = 1'b0;
      tests++; if (Q_count !== 3'd1 || RF_en !== 1'b0 || PEND !== 32'h80) begin fails++; $display("FAIL ld_n1 got q=%0d en=%0b pend=%h exp 1/0/00000080", Q_count, RF_en, PEND); end
      cyc();
      tests++; if ({RF_en, RF_wa, RF_wd} !== {1'b1, 5'd7, 32'h12345678}) begin fails++; $display("FAIL ld_write got %0b/%0d/%h exp 1/7/12345678", RF_en, RF_wa, RF_wd); end
      tests++; if (PEND !== 32'd0 || Q_count !== 3'd0) begin fails++; $display("FAIL ld_clear got pend=%h q=%0d exp 0/0", PEND, Q_count); end
   endtask
   task automatic test_full();
      int acc = 0;
      ALU_valid = 1'b1; ALU_wa = 5'd1; ALU_wd = 32'h11;
      for (int i = 0; i < 5; i++) begin
         LD_valid = 1'b1; LD_wa = 5'(10 + i); LD_wd = 32'hA0 + i;
         #1;
         if (LD_ready) acc++;
         cyc();
      end
      LD_valid = 1'b0;
      #1;
      tests++; if (acc != 4) begin fails++; $display("FAIL full_acc got %0d exp 4", acc); end
      tests++; if (LD_ready !== 1'b0 || Q_count !== 3'd4) begin fails++; $display("FAIL full_state got ready=%0b q=%0d exp 0/4", LD_ready, Q_count); end
      ALU_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         tests++; if ({RF_en, RF_wa, RF_wd} !== {1'b1, 5'(10 + i), 32'hA0 + i}) begin fails++; $display("FAIL drain%0d got %0b/%0d/%h exp 1/%0d/%h", i, RF_en, RF_wa, RF_wd, 10 + i, 32'hA0 + i); end
         if (i == 0) begin
            tests++; if (LD_ready !== 1'b1 || Q_count !== 3'd3) begin fails++; $display("FAIL drain_ready got ready=%0b q=%0d exp 1/3", LD_ready, Q_count); end
         end
      end
      tests++; if (Q_count !== 3'd0) begin fails++; $display("FAIL drain_empty got %0d exp 0", Q_count); end
   endtask
   task automatic test_starve();
      ALU_valid = 1'b1; ALU_wa = 5'd3; ALU_wd = 32'h33;
      LD_valid = 1'b1; LD_wa = 5'd20; LD_wd = 32'h55;
      cyc();
      LD_valid = 1'b0;
      cyc(); cyc();
      tests++; if (STALL_REQ !== 1'b0) begin fails++; $display("FAIL starve2 got %0b exp 0", STALL_REQ); end
      cyc();
      tests++; if (STALL_REQ !== 1'b1) begin fails++; $display("FAIL starve3 got %0b exp 1", STALL_REQ); end
      cyc();
      tests++; if (STALL_REQ !== 1'b1 || RF_en !== 1'b1 || RF_wa !== 5'd3 || Q_count !== 3'd1) begin fails++; $display("FAIL starve_alu got stall=%0b en=%0b wa=%0d q=%0d exp 1/1/3/1", STALL_REQ, RF_en, RF_wa, Q_count); end
      ALU_valid = 1'b0;
      cyc();
      tests++; if (STALL_REQ !== 1'b0 || RF_wa !== 5'd20 || RF_wd !== 32'h55 || Q_count !== 3'd0) begin fails++; $display("FAIL starve_pop got stall=%0b wa=%0d wd=%h q=%0d exp 0/20/55/0", STALL_REQ, RF_wa, RF_wd, Q_count); end
   endtask
   task automatic test_collision();
      SB_set = 1'b1; SB_rd = 5'd9;
      ALU_valid = 1'b1; ALU_wa = 5'd2; ALU_wd = 32'h22;
      LD_valid = 1'b1; LD_wa = 5'd9; LD_wd = 32'h99;
      cyc();
      LD_valid = 1'b0; ALU_valid = 1'b0;
      cyc();
      SB_set = 1'b0;
      tests++; if (PEND !== 32'h200 || RF_wa !== 5'd9 || RF_en !== 1'b1) begin fails++; $display("FAIL collide got pend=%h wa=%0d en=%0b exp 00000200/9/1", PEND, RF_wa, RF_en); end
      SB_set = 1'b1; SB_rd = 5'd0;
      cyc();
      SB_set = 1'b0;
      tests++; if (PEND !== 32'h200) begin fails++; $display("FAIL sb_r0 got %h exp 00000200", PEND); end
   endtask
   task automatic test_zero_load();
      ALU_valid = 1'b1; ALU_wa = 5'd4; ALU_wd = 32'h44;
      LD_valid = 1'b1; LD_wa = 5'd0; LD_wd = 32'hAB;
      cyc();
      LD_valid = 1'b0; ALU_valid = 1'b0;
      cyc();
      tests++; if (RF_en !== 1'b0 || Q_count !== 3'd0) begin fails++; $display("FAIL ld_r0 got en=%0b q=%0d exp 0/0", RF_en, Q_count); end
   endtask
   task automatic test_mid_reset();
      ALU_valid = 1'b1; ALU_wa = 5'd6; ALU_wd = 32'h66;
      LD_valid = 1'b1; LD_wa = 5'd15; LD_wd = 32'hF0;
      cyc(); cyc();
      LD_valid = 1'b0;
      tests++; if (Q_count !== 3'd2) begin fails++; $display("FAIL mid_q got %0d exp 2", Q_count); end
      RST_N = 1'b0; ALU_valid = 1'b0;
      cyc();
      tests++; if (Q_count !== 3'd0 || RF_en !== 1'b0 || PEND !== 32'd0 || LD_ready !== 1'b0) begin fails++; $display("FAIL mid_rst got q=%0d en=%0b pend=%h ready=%0b exp 0/0/0/0", Q_count, RF_en, PEND, LD_ready); end
      RST_N = 1'b1;
      cyc();
      tests++; if (RF_en !== 1'b0 || Q_count !== 3'd0) begin fails++; $display("FAIL mid_after got en=%0b q=%0d exp 0/0", RF_en, Q_count); end
   endtask
   initial begin
      test_reset();
      test_alu();
      test_load();
      test_full();
      test_starve();
      test_collision();
      test_zero_load();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
